// File: rtl/feed_pkg.sv
// Shared types and default geometry for the systolic feed controller.
package feed_pkg;

    localparam int ROWS   = 7;
    localparam int DEPTH  = 7;
    localparam int DRAIN  = 7;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } feed_state_t;

    // Wide enough for the longer of the FEED and DRAIN phases; never wraps.
    function automatic int cnt_width(input int rows, input int depth, input int drain);
        int top;
        top = ((depth + rows - 1) > drain) ? (depth + rows - 1) : drain;
        return $clog2(top + 1);
    endfunction

endpackage

// File: rtl/skew_window_gen.sv
// Decodes the feed counter into the diagonal (skewed) row enable window.
module skew_window_gen #(
    parameter int ROWS  = feed_pkg::ROWS,
    parameter int DEPTH = feed_pkg::DEPTH,
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] t_i,
    output logic [ROWS-1:0]  window_o
);

    // Row r is live for DEPTH consecutive steps starting at step r.
    always_comb begin
        window_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            window_o[r] = (32'(t_i) >= 32'(r)) && (32'(t_i) < 32'(r + DEPTH));
        end
    end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequences one load/feed/drain pass of the row feeders into the systolic array.
module systolic_feed_ctrl #(
    parameter int ROWS  = feed_pkg::ROWS,
    parameter int DEPTH = feed_pkg::DEPTH,
    parameter int DRAIN = feed_pkg::DRAIN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    output logic            feed_load,
    output logic [ROWS-1:0] feed_en,
    output logic [ROWS-1:0] row_valid,
    output logic            mac_clear,
    output logic            mac_en,
    output logic            busy,
    output logic            done
);

    import feed_pkg::*;

    localparam int               CNT_W      = cnt_width(ROWS, DEPTH, DRAIN);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(DEPTH + ROWS - 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN - 1);

    feed_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROWS-1:0]  window;

    skew_window_gen #(
        .ROWS  (ROWS),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_window (
        .t_i      (cnt_q),
        .window_o (window)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall only freezes the two counted phases; all other states advance unconditionally.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                state_d = ST_FEED;
                cnt_d   = '0;
            end
            ST_FEED: begin
                if (!stall) begin
                    if (cnt_q == FEED_LAST) begin
                        state_d = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, even before the reset edge lands.
    always_comb begin
        feed_load = 1'b0;
        feed_en   = '0;
        row_valid = '0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (!reset) begin
            busy = (state_q != ST_IDLE);
            unique case (state_q)
                ST_LOAD: begin
                    feed_load = 1'b1;
                    mac_clear = 1'b1;
                end
                ST_FEED: begin
                    if (!stall) begin
                        feed_en   = window;
                        row_valid = window;
                        mac_en    = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    mac_en = !stall;
                end
                ST_DONE: begin
                    done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/systolic_feed_ctrl.md
SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 Parameter ROWS, default 7: number of row data_feeder instances sequenced.
REQ-002 Parameter DEPTH, default 7: bytes per feeder, one 8-bit byte per shift; 56-bit load at default.
REQ-003 Parameter DRAIN, default 7: pipeline flush cycles after the last byte.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 start  input  1  request one feed pass; sampled only in IDLE.
REQ-007 stall  input  1  downstream array not ready; freezes sequencing.
REQ-008 feed_load  output  1  one-cycle pulse; feeders capture 56-bit operands.
REQ-009 feed_en  output  ROWS  per-row shift enable to feeders.
REQ-010 row_valid  output  ROWS  per-row byte-valid; array zero-gates rows where low.
REQ-011 mac_clear  output  1  one-cycle accumulator clear, coincident with feed_load.
REQ-012 mac_en  output  1  array accumulate enable.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, FEED, DRAIN, DONE; all outputs are Moore-decoded from registered state and counter.
REQ-016 IDLE: start=1 at an edge -> LOAD next cycle; start=0 -> stay in IDLE.
REQ-017 LOAD lasts exactly 1 cycle with feed_load=1 and mac_clear=1, then enters FEED with counter t=0.
REQ-018 FEED runs t = 0 .. DEPTH+ROWS-2, which is 13 unstalled cycles at defaults.
REQ-019 In FEED, row r: row_valid[r]=feed_en[r]=1 iff r <= t < r+DEPTH and stall=0; each row gets exactly DEPTH enables.
REQ-020 mac_en SHALL be 1 in FEED and DRAIN when stall=0, and 0 otherwise.
REQ-021 After the last FEED cycle, enter DRAIN with counter reloaded to 0; DRAIN lasts DRAIN unstalled cycles.
REQ-022 DONE lasts 1 cycle with done=1 and busy=1, then returns to IDLE.
REQ-023 stall=1 in FEED or DRAIN: counter and state hold; feed_en, row_valid and mac_en are all 0.
REQ-024 stall in IDLE, LOAD or DONE SHALL be ignored; those states advance regardless.
REQ-025 start while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 start high in the DONE cycle SHALL be ignored; a new pass requires start in IDLE.
REQ-027 Counter width SHALL be $clog2(max(DEPTH+ROWS-1, DRAIN)+1); no wrap is reachable.
REQ-028 ROWS=1 SHALL degenerate to DEPTH FEED cycles with no skew.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE and counter 0, overriding start and stall, including mid-FEED or mid-DRAIN.
REQ-030 Output values while in reset: feed_load=0, feed_en=0, row_valid=0, mac_clear=0, mac_en=0, busy=0, done=0.
REQ-031 The first start after reset deasserts SHALL be honoured in the next cycle.

Structure
REQ-032 Shared package feed_pkg SHALL hold the state enum feed_state_t and the default constants ROWS, DEPTH, DRAIN and BYTE_W=8.
REQ-033 One sub-module, skew_window_gen, SHALL decode t into the ROWS-wide window mask; the FSM and counter live in the top module.
REQ-034 The block SHALL contain no datapath storage; operands pass directly to the feeders.

Verification (ROWS=7, DEPTH=7, DRAIN=7; cycle numbers count from the start edge = 0)
REQ-035 Single pass: start pulse at 0 -> LOAD at cycle 1, FEED cycles 2-14, DRAIN cycles 15-21, done at cycle 22, busy 1-22.
REQ-036 Skew: row0 feed_en high at cycles 2-8, row6 high at cycles 8-14; bench checks 7 enables per row and the feeder byte sequence matches the loaded operand MSB-first.
REQ-037 Stall: stall=1 at cycles 5-7 -> feed_en=0 and mac_en=0 there, everything shifts +3, done at cycle 25.
REQ-038 Reset mid-FEED: reset at cycle 6 -> cycle 7 IDLE with all outputs 0; a new start at 9 gives done at cycle 31.
REQ-039 Start while busy: start held 0-22 -> exactly one done, at cycle 22.
REQ-040 Back-to-back: start pulses at 0 and 23 -> done at 22 and 45, with a second feed_load at cycle 24.
